// File: rtl/seg_pkg.sv
// Shared constants, state encoding and helpers for the 7-segment scan driver.
// Optional blink feature is enabled by defining SEG_BLINK_EN (see seg_scan_driver).
package seg_pkg;

    localparam int SEG_DIGITS = 4;
    localparam int BCD_W      = 16;

    // Cathode patterns {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    // Map one BCD digit to its cathode pattern; non-decimal codes blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    // Double-dabble correction: add 3 to every nibble that is 5 or more,
    // so the following left shift carries correctly into the next decade.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] adjusted;
        adjusted = bcd;
        for (int k = 0; k < SEG_DIGITS; k++) begin
            if (bcd[k*4 +: 4] >= 4'd5) begin
                adjusted[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
            end
        end
        return adjusted;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Score load handshake between game logic (master) and the display driver (slave).
interface seg_scan_driver_if #(
    parameter int SCORE_W = 14
);
    logic [SCORE_W-1:0] score;
    logic               score_valid;
    logic               busy;

    modport master (output score, output score_valid, input busy);
    modport slave  (input score, input score_valid, output busy);
endinterface

// File: rtl/seg_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one accept, SCORE_W
// shift cycles, one DONE cycle that presents the result to the display.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int SCORE_W   = 14,
    parameter int MAX_SCORE = 9999
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [SCORE_W-1:0] score_i,
    input  logic               score_valid_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [BCD_W-1:0]   bcd_o
);

    localparam int                 CNT_W    = $clog2(SCORE_W);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(SCORE_W - 1);
    localparam logic [SCORE_W-1:0] MAX_VAL  = SCORE_W'(MAX_SCORE);

    conv_state_e        state_q;
    logic [SCORE_W-1:0] bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;

    logic [SCORE_W-1:0] score_clamped;
    logic [BCD_W-1:0]   bcd_adj;

    assign score_clamped = (score_i > MAX_VAL) ? MAX_VAL : score_i;
    assign bcd_adj       = dabble_adjust(bcd_q);

    // Converter FSM with registered busy/done; clr aborts any conversion.
    always_ff @(posedge clk) begin
        // NOTE: every register here is assigned with <= so all state updates
        // see the values from before the edge, exactly like the hardware.
        if (clr) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (score_valid_i) begin
                        bin_q   <= score_clamped;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
                    bin_q <= {bin_q[SCORE_W-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed 7-segment driver: synchronizes the divided scan clock
// into a one-cycle tick, converts the score to BCD, and scans anodes and
// cathodes with leading-zero blanking.
// Optional feature: define SEG_BLINK_EN to add blink_clk/blink_en, which
// blank all anodes while enabled and the synchronized blink clock is high.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCORE_W   = 14,
    parameter int MAX_SCORE = 9999
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     segclk,
`ifdef SEG_BLINK_EN
    input  logic                     blink_clk,
    input  logic                     blink_en,
`endif
    seg_scan_driver_if.slave         bus,
    output logic [SEG_DIGITS-1:0]    an,
    output logic [6:0]               seg,
    output logic                     dp
);

    logic                  segclk_meta_q;
    logic                  segclk_sync_q;
    logic                  segclk_prev_q;
    logic                  scan_tick_q;

    logic [1:0]            idx_q;
    logic [1:0]            idx_d;
    logic [BCD_W-1:0]      display_q;
    logic [BCD_W-1:0]      display_d;
    logic [SEG_DIGITS-1:0] an_scan_q;
    logic [SEG_DIGITS-1:0] an_scan_d;
    logic [6:0]            seg_q;
    logic [6:0]            seg_d;
    logic                  dp_q;

    logic                  conv_done;
    logic [BCD_W-1:0]      conv_bcd;
    logic [3:0]            digit_sel;
    logic [SEG_DIGITS-1:0] lead_zero;
    logic                  zero_run;
    logic                  blank_sel;

    bin2bcd_seq #(
        .SCORE_W   (SCORE_W),
        .MAX_SCORE (MAX_SCORE)
    ) u_bin2bcd (
        .clk           (clk),
        .clr           (clr),
        .score_i       (bus.score),
        .score_valid_i (bus.score_valid),
        .busy_o        (bus.busy),
        .done_o        (conv_done),
        .bcd_o         (conv_bcd)
    );

    // Two-flop synchronizer, edge-detect flop and registered scan tick.
    always_ff @(posedge clk) begin
        if (clr) begin
            segclk_meta_q <= 1'b0;
            segclk_sync_q <= 1'b0;
            segclk_prev_q <= 1'b0;
            scan_tick_q   <= 1'b0;
        end else begin
            segclk_meta_q <= segclk;
            segclk_sync_q <= segclk_meta_q;
            segclk_prev_q <= segclk_sync_q;
            scan_tick_q   <= segclk_sync_q & ~segclk_prev_q;
        end
    end

    // Next display contents, digit index and scan outputs; a DONE copy in
    // the same cycle as a tick is already visible to the scan.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        display_d = display_q;
        idx_d     = idx_q;
        an_scan_d = an_scan_q;
        seg_d     = seg_q;
        lead_zero = '0;
        zero_run  = 1'b1;

        if (conv_done) begin
            display_d = conv_bcd;
        end
        if (scan_tick_q) begin
            idx_d = idx_q + 2'd1;
        end

        for (int k = SEG_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run & (display_d[k*4 +: 4] == 4'd0);
            lead_zero[k] = zero_run;
        end

        digit_sel = display_d[{idx_d, 2'b00} +: 4];
        blank_sel = (idx_d != 2'd0) && lead_zero[idx_d];

        if (scan_tick_q) begin
            an_scan_d = ~(SEG_DIGITS'(1) << idx_d);
            seg_d     = blank_sel ? SEG_BLANK : seg_decode(digit_sel);
        end
    end

    // Display register, scan index and registered scan outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            display_q <= '0;
            idx_q     <= 2'd3;
            an_scan_q <= '1;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            display_q <= display_d;
            idx_q     <= idx_d;
            an_scan_q <= an_scan_d;
            seg_q     <= seg_d;
            dp_q      <= 1'b1;
        end
    end

`ifdef SEG_BLINK_EN
    logic                  blink_meta_q;
    logic                  blink_sync_q;
    logic [SEG_DIGITS-1:0] an_q;

    // Blink clock synchronizer and anode override; scanning runs on beneath it.
    always_ff @(posedge clk) begin
        if (clr) begin
            blink_meta_q <= 1'b0;
            blink_sync_q <= 1'b0;
            an_q         <= '1;
        end else begin
            blink_meta_q <= blink_clk;
            blink_sync_q <= blink_meta_q;
            an_q         <= (blink_en && blink_sync_q) ? '1 : an_scan_d;
        end
    end

    assign an = an_q;
`else
    assign an = an_scan_q;
`endif

    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: stimulus pushes the expected
// anode/cathode pair for each scan step, a monitor pops on every anode change.
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       clr;
    logic       segclk;
`ifdef SEG_BLINK_EN
    logic       blink_clk;
    logic       blink_en;
`endif
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    seg_scan_driver_if #(.SCORE_W(14)) bus ();

    seg_scan_driver #(
        .SCORE_W   (14),
        .MAX_SCORE (9999)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .segclk    (segclk),
`ifdef SEG_BLINK_EN
        .blink_clk (blink_clk),
        .blink_en  (blink_en),
`endif
        .bus       (bus),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec   = 0;
    int   n_miss  = 0;
    int   model_val = 0;
    int   model_idx = 3;
    bit   mon_en  = 1'b0;

    logic [6:0] pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    // Reference: what the display shows for a decimal value at a digit position.
    function automatic exp_t model_digit(input int val, input int idx, input string tag);
        exp_t e;
        int   d;
        d     = (val / pow10(idx)) % 10;
        e.an  = ~(4'b0001 << idx);
        e.seg = (idx > 0 && val < pow10(idx)) ? 7'b1111111 : pat[d];
        e.tag = tag;
        return e;
    endfunction

    task automatic scan_step(input string tag);
        model_idx = (model_idx + 1) % 4;
        exp_q.push_back(model_digit(model_val, model_idx, tag));
        segclk = 1'b1;
        repeat (4) @(negedge clk);
        segclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic scan4(input string tag);
        for (int i = 0; i < 4; i++) scan_step(tag);
    endtask

    // Load a score; optionally fire a second valid at cycle drop_c or clr at clr_c.
    task automatic load(input int s, input int s2, input int drop_c, input int clr_c, input string tag);
        int  c;
        int  n;
        bit  aborted;
        @(negedge clk);
        bus.score       = 14'(s);
        bus.score_valid = 1'b1;
        @(negedge clk);
        bus.score_valid = 1'b0;
        c = 1;
        n = 0;
        aborted = 1'b0;
        while (bus.busy && c < 100) begin
            if (c == drop_c) begin
                bus.score       = 14'(s2);
                bus.score_valid = 1'b1;
            end
            if (c == clr_c) clr = 1'b1;
            n++;
            @(negedge clk);
            bus.score_valid = 1'b0;
            if (clr) begin
                clr = 1'b0;
                aborted = 1'b1;
                check({tag, "/busy_after_clr"}, bus.busy, 0);
                check({tag, "/an_after_clr"}, an, 4'hF);
                break;
            end
            c++;
        end
        if (aborted) begin
            model_val = 0;
            model_idx = 3;
        end else begin
            check({tag, "/busy_cycles"}, n, 15);
            model_val = (s > 9999) ? 9999 : s;
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every anode change to a lit digit is one scan presentation.
    initial begin
        logic [3:0] prev_an;
        exp_t       e;
        prev_an = 4'hF;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_an = an;
            end else if (an !== prev_an) begin
                prev_an = an;
                if (an !== 4'hF) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_scan", an, 4'hF);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.tag, "/an"}, an, e.an);
                        check({e.tag, "/seg"}, seg, e.seg);
                        check({e.tag, "/dp"}, dp, 1);
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int s;
        clr             = 1'b1;
        segclk          = 1'b0;
        bus.score       = '0;
        bus.score_valid = 1'b0;
`ifdef SEG_BLINK_EN
        blink_clk       = 1'b0;
        blink_en        = 1'b0;
`endif
        repeat (2) @(negedge clk);
        segclk = 1'b1;
        repeat (2) @(negedge clk);
        segclk = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("reset/an", an, 4'hF);
        check("reset/seg", seg, 7'h7F);
        check("reset/dp", dp, 1);
        check("reset/busy", bus.busy, 0);
        repeat (6) @(negedge clk);
        check("reset/an_no_tick", an, 4'hF);
        mon_en = 1'b1;

        scan4("reset_scan");
        load(1234, 0, 0, 0, "v1234");
        scan4("v1234");
        load(16383, 0, 0, 0, "clamp");
        scan4("clamp");
        load(7, 0, 0, 0, "v7");
        scan4("v7");
        load(100, 0, 0, 0, "v100");
        scan4("v100");
        load(4321, 55, 5, 0, "drop");
        scan4("drop");
        load(8888, 0, 0, 8, "abort");
        scan4("abort");

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0:       s = $urandom_range(0, 9);
                1:       s = $urandom_range(10, 999);
                2:       s = $urandom_range(1000, 9999);
                default: s = $urandom_range(0, 16383);
            endcase
            load(s, 0, 0, 0, $sformatf("rand%0d_%0d", i, s));
            for (int k = 0; k < 1 + int'($urandom_range(0, 4)); k++) begin
                scan_step($sformatf("rand%0d_%0d", i, s));
            end
        end

`ifdef SEG_BLINK_EN
        blink_en  = 1'b1;
        blink_clk = 1'b1;
        repeat (4) @(negedge clk);
        check("blink/an_forced", an, 4'hF);
        exp_q.push_back(model_digit(model_val, model_idx, "blink_resume"));
        blink_clk = 1'b0;
        repeat (4) @(negedge clk);
        blink_en = 1'b0;
`endif

        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
